// File: rtl/cont_bcd_timer.sv
// Cascaded BCD up/down counter with preset, boundary detection and
// IDLE/RUN/HALT control; WRAP selects halt-at-boundary or wrap-around.
module cont_bcd_timer #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  En,
  input  logic                  Dir,
  input  logic                  Load,
  input  logic [4*DIGITS-1:0]   Din,
  output logic [4*DIGITS-1:0]   Q,
  output logic                  Tc,
  output logic                  Done,
  output logic                  Busy,
  output logic                  Err
);

  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINES = {DIGITS{4'd9}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t         state_r;
  logic [W-1:0]   q_r;
  logic           done_r;
  logic           busy_r;
  logic           err_r;

  logic [W-1:0]   boundary_s;
  logic [W-1:0]   step_s;
  logic           at_bound_s;
  logic           step_bound_s;
  logic           din_ok_s;

  function automatic logic bcd_valid(input logic [W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // A decade moves only while every lower decade sits at its rollover value.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         carry;
    logic [3:0]   d;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      d = v[4*i +: 4];
      if (carry) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            carry       = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            carry       = 1'b0;
          end
        end
      end else begin
        r[4*i +: 4] = d;
      end
    end
    return r;
  endfunction

  // Boundary and next-count evaluation for the currently sampled direction.
  always_comb begin
    boundary_s   = Dir ? ALL_NINES : {W{1'b0}};
    at_bound_s   = (q_r == boundary_s);
    step_s       = bcd_step(q_r, Dir);
    step_bound_s = (step_s == boundary_s);
    din_ok_s     = bcd_valid(Din);
  end

  // Control state, count register and registered status pulses.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
      q_r     <= {W{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      err_r  <= 1'b0;
      if (Load) begin
        if (din_ok_s) begin
          q_r     <= Din;
          state_r <= RUN;
          busy_r  <= 1'b1;
        end else begin
          err_r   <= 1'b1;
        end
      end else begin
        case (state_r)
          RUN: begin
            if (En) begin
              if (!WRAP && at_bound_s) begin
                // Already sitting on the boundary: terminate without stepping.
                state_r <= HALT;
                busy_r  <= 1'b0;
                done_r  <= 1'b1;
              end else begin
                q_r    <= step_s;
                done_r <= step_bound_s;
                if (!WRAP && step_bound_s) begin
                  state_r <= HALT;
                  busy_r  <= 1'b0;
                end else begin
                  busy_r  <= 1'b1;
                end
              end
            end else begin
              busy_r <= 1'b1;
            end
          end
          IDLE: begin
            busy_r <= 1'b0;
          end
          HALT: begin
            busy_r <= 1'b0;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign Q    = q_r;
  assign Tc   = at_bound_s;
  assign Done = done_r;
  assign Busy = busy_r;
  assign Err  = err_r;

endmodule
